// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the boot ROM arbiter
// Contents: owner_e (IDLE/IGNT/DGNT), load size encodings SZ_B/SZ_H/SZ_W,
// default starvation limit STARVE_MAX_DEF.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/rom_load_align.sv
// rtl/rom_load_align.sv - combinational sub-word load extraction and extension
// Ports: rom_dout (32-bit memory word), lane (byte address bits [1:0]),
// size (SZ_B/SZ_H/SZ_W, 3 reserved), sign_ext; rdata (extended result,
// 0 on error), err (misaligned or reserved size).
module rom_load_align
    import rom_arb_pkg::*;
(
    input  logic [31:0] rom_dout,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rom_dout[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rom_dout[31:16] : rom_dout[15:0];
        rdata    = '0;
        err      = 1'b0;
        case (size)
            SZ_B: rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_H: begin
                if (lane[0]) err = 1'b1;
                else         rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                if (lane != 2'b00) err = 1'b1;
                else               rdata = rom_dout;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - fetch/load arbiter and read sequencer for the boot ROM
// Ports: clk, rst (sync, active-high); fetch port i_req/i_addr/i_gnt/
// i_rvalid/i_rdata; load port d_req/d_addr/d_size/d_signed/d_gnt/d_rvalid/
// d_rdata/d_err; ROM side rom_addr/rom_dout (registered, one-cycle latency).
// Build option: ROM_ARB_RR_EN selects round-robin instead of data priority
// with starvation guard.
module rom_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = rom_arb_pkg::STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_dout
);
    import rom_arb_pkg::*;

    // state_d: owner of the access issued this cycle; state_q: owner of the
    // access whose data is on rom_dout this cycle.
    owner_e            state_d, state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              prefer_i;
    logic [31:0]       align_rdata;
    logic              align_err;

`ifdef ROM_ARB_RR_EN
    logic last_d;

    assign prefer_i = last_d;

    always_ff @(posedge clk) begin
        if (rst)                  last_d <= 1'b0;
        else if (state_d == IGNT) last_d <= 1'b0;
        else if (state_d == DGNT) last_d <= 1'b1;
    end
`else
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    assign prefer_i = (starve_cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst || !i_req || state_d == IGNT)
            starve_cnt <= '0;
        else if (state_d == DGNT && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= rom_addr;
            if (state_d == DGNT) begin
                lane_q <= d_addr[1:0];
                size_q <= d_size;
                sign_q <= d_signed;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        if (!rst) begin
            if (i_req && d_req) state_d = prefer_i ? IGNT : DGNT;
            else if (i_req)     state_d = IGNT;
            else if (d_req)     state_d = DGNT;
        end
    end

    rom_load_align u_align (
        .rom_dout (rom_dout),
        .lane     (lane_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .rdata    (align_rdata),
        .err      (align_err)
    );

    // Responses are masked while rst is high so a reset in the response
    // cycle drops the in-flight read.
    always_comb begin
        i_gnt    = (state_d == IGNT);
        d_gnt    = (state_d == DGNT);
        rom_addr = addr_q;
        if (rst)        rom_addr = '0;
        else if (i_gnt) rom_addr = i_addr;
        else if (d_gnt) rom_addr = d_addr;
        i_rvalid = (state_q == IGNT) && !rst;
        d_rvalid = (state_q == DGNT) && !rst;
        i_rdata  = i_rvalid ? rom_dout : 32'h0;
        d_rdata  = (d_rvalid && !align_err) ? align_rdata : 32'h0;
        d_err    = d_rvalid && align_err;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard testbench for rom_arbiter with ROM model
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [9:0]  i_addr = '0;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [9:0]  d_addr = '0;
    logic [1:0]  d_size = '0;
    logic        d_signed = 1'b0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout = '0;

    logic [31:0] mem [256];
    logic [31:0] iq [$];
    logic [32:0] dq [$];
    int          checks = 0;
    int          fails = 0;
    logic        last_d = 1'b0;
    logic        eg_i;

    always #5 clk = ~clk;

    rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_size   (d_size),
        .d_signed (d_signed),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always @(posedge clk) rom_dout <= mem[rom_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per response beat.
    always @(negedge clk) begin
        logic [32:0] de;
        if (i_rvalid) begin
            if (iq.size() == 0) chk("i_rvalid_unexpected", 32'(i_rvalid), 32'h0);
            else                chk("i_rdata", i_rdata, iq.pop_front());
        end else begin
            chk("i_rdata_idle", i_rdata, 32'h0);
        end
        if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'h0);
            else begin
                de = dq.pop_front();
                chk("d_rdata", d_rdata, de[31:0]);
                chk("d_err", 32'(d_err), 32'(de[32]));
            end
        end else begin
            chk("d_rdata_idle", d_rdata, 32'h0);
            chk("d_err_idle", 32'(d_err), 32'h0);
        end
    end

    task automatic cyc(input logic ir, input logic [9:0] ia, input logic dr,
                       input logic [9:0] da, input logic [1:0] ds, input logic sg,
                       input logic eig, input logic edg, input logic [31:0] iexp,
                       input logic [31:0] dexp, input logic derr, input logic push);
        @(posedge clk); #1;
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_size = ds; d_signed = sg;
        @(negedge clk);
        chk("i_gnt", 32'(i_gnt), 32'(eig));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        if (eig) begin
            chk("rom_addr_i", 32'(rom_addr), 32'(ia));
            last_d = 1'b0;
            if (push) iq.push_back(iexp);
        end
        if (edg) begin
            chk("rom_addr_d", 32'(rom_addr), 32'(da));
            last_d = 1'b1;
            if (push) dq.push_back({derr, dexp});
        end
    endtask

    task automatic idle();
        cyc(1'b0, 10'h0, 1'b0, 10'h0, SZ_B, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_gnt"},    32'(i_gnt),    32'h0);
        chk({tag, "_d_gnt"},    32'(d_gnt),    32'h0);
        chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'h0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'h0);
        chk({tag, "_d_err"},    32'(d_err),    32'h0);
        chk({tag, "_i_rdata"},  i_rdata,       32'h0);
        chk({tag, "_d_rdata"},  d_rdata,       32'h0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[8'h00] = 32'h00000093;
        mem[8'h20] = 32'hDEAD12B7;
        mem[8'h21] = 32'hEEF18193;
        mem[8'h87] = 32'h6C6C6568;
        mem[8'h88] = 32'h6F77206F;
        mem[8'h89] = 32'h0D646C72;

        // Reset held with both requests raised: no grant.
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_req");
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        // Fetches.
        cyc(1, 10'h000, 0, 10'h0, SZ_W, 0, 1, 0, 32'h00000093, 32'h0, 0, 1);
        cyc(1, 10'h084, 0, 10'h0, SZ_W, 0, 1, 0, 32'hEEF18193, 32'h0, 0, 1);
        idle();

        // Sub-word and word loads.
        cyc(0, 10'h0, 1, 10'h21C, SZ_B, 0, 0, 1, 32'h0, 32'h00000068, 0, 1);
        cyc(0, 10'h0, 1, 10'h080, SZ_B, 1, 0, 1, 32'h0, 32'hFFFFFFB7, 0, 1);
        cyc(0, 10'h0, 1, 10'h082, SZ_H, 1, 0, 1, 32'h0, 32'hFFFFDEAD, 0, 1);
        cyc(0, 10'h0, 1, 10'h082, SZ_H, 0, 0, 1, 32'h0, 32'h0000DEAD, 0, 1);
        cyc(0, 10'h0, 1, 10'h223, SZ_B, 1, 0, 1, 32'h0, 32'h0000006F, 0, 1);
        cyc(0, 10'h0, 1, 10'h085, SZ_B, 1, 0, 1, 32'h0, 32'hFFFFFF81, 0, 1);
        cyc(0, 10'h0, 1, 10'h086, SZ_H, 0, 0, 1, 32'h0, 32'h0000EEF1, 0, 1);
        cyc(0, 10'h0, 1, 10'h084, SZ_W, 0, 0, 1, 32'h0, 32'hEEF18193, 0, 1);

        // Error loads, then a normal load right behind them.
        cyc(0, 10'h0, 1, 10'h086, SZ_W, 0, 0, 1, 32'h0, 32'h0, 1, 1);
        cyc(0, 10'h0, 1, 10'h081, SZ_H, 1, 0, 1, 32'h0, 32'h0, 1, 1);
        cyc(0, 10'h0, 1, 10'h000, 2'd3, 0, 0, 1, 32'h0, 32'h0, 1, 1);
        cyc(0, 10'h0, 1, 10'h21C, SZ_W, 0, 0, 1, 32'h0, 32'h6C6C6568, 0, 1);
        idle();

        // Back-to-back fetches.
        cyc(1, 10'h21C, 0, 10'h0, SZ_W, 0, 1, 0, 32'h6C6C6568, 32'h0, 0, 1);
        cyc(1, 10'h220, 0, 10'h0, SZ_W, 0, 1, 0, 32'h6F77206F, 32'h0, 0, 1);
        cyc(1, 10'h224, 0, 10'h0, SZ_W, 0, 1, 0, 32'h0D646C72, 32'h0, 0, 1);
        idle();

        // Conflict: both held for 10 cycles.
        for (int k = 0; k < 10; k++) begin
`ifdef ROM_ARB_RR_EN
            eg_i = last_d;
`else
            eg_i = (k % 5 == 4);
`endif
            cyc(1, 10'h000, 1, 10'h084, SZ_W, 0, eg_i, !eg_i,
                32'h00000093, 32'hEEF18193, 0, 1);
        end
        idle();
        idle();

        // Reset in the response cycle drops the load.
        cyc(0, 10'h0, 1, 10'h084, SZ_W, 0, 0, 1, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_flight");
        @(posedge clk); #1;
        rst = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_flight");

        // Normal operation resumes.
        cyc(0, 10'h0, 1, 10'h080, SZ_B, 0, 0, 1, 32'h0, 32'h000000B7, 0, 1);
        idle();
        idle();

        chk("iq_drained", 32'(iq.size()), 32'h0);
        chk("dq_drained", 32'(dq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
